// File: rtl/ssd_scan_driver.sv
// Multiplexed seven-segment driver for NUM_DIGITS common-anode digits.
// Ports: clk/rst_n, inp/idp/en/lzb/bright/load in; cc/odp/an/idx/frame out (active-low pins).
module ssd_scan_driver #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int BRIGHT_W    = 4,
  parameter int IDX_W       = $clog2(NUM_DIGITS)
) (
  input  logic                    ssd_scan_driver_port_clk,
  input  logic                    ssd_scan_driver_port_rst_n,
  input  logic [4*NUM_DIGITS-1:0] ssd_scan_driver_port_inp,
  input  logic [NUM_DIGITS-1:0]   ssd_scan_driver_port_idp,
  input  logic [NUM_DIGITS-1:0]   ssd_scan_driver_port_en,
  input  logic                    ssd_scan_driver_port_lzb,
  input  logic [BRIGHT_W-1:0]     ssd_scan_driver_port_bright,
  input  logic                    ssd_scan_driver_port_load,
  output logic [6:0]              ssd_scan_driver_port_cc,
  output logic                    ssd_scan_driver_port_odp,
  output logic [NUM_DIGITS-1:0]   ssd_scan_driver_port_an,
  output logic [IDX_W-1:0]        ssd_scan_driver_port_idx,
  output logic                    ssd_scan_driver_port_frame
);

  localparam int PRE_W = $clog2(REFRESH_DIV);

  logic                         clk;
  logic                         rst_n;
  logic [PRE_W-1:0]             r_pre;
  logic [IDX_W-1:0]             r_idx;
  logic                         r_frame;
  logic [BRIGHT_W-1:0]          r_phase;
  logic [BRIGHT_W-1:0]          r_bright;
  logic [NUM_DIGITS-1:0][3:0]   r_nib;
  logic [NUM_DIGITS-1:0]        r_dp;
  logic [NUM_DIGITS-1:0]        r_mask;
  logic [NUM_DIGITS-1:0]        r_an;
  logic [6:0]                   r_cc;
  logic                         r_odp;

  logic                         w_tick;
  logic                         w_last;
  logic [NUM_DIGITS-1:0]        w_mask;
  logic                         w_stop;
  logic [3:0]                   w_nib;
  logic [6:0]                   w_seg;
  logic                         w_lit;
  logic [NUM_DIGITS-1:0]        w_an;
  logic [6:0]                   w_cc;
  logic                         w_odp;

  assign clk   = ssd_scan_driver_port_clk;
  assign rst_n = ssd_scan_driver_port_rst_n;

  assign w_tick = (r_pre == PRE_W'(REFRESH_DIV - 1));
  assign w_last = (r_idx == IDX_W'(NUM_DIGITS - 1));

  // Blank from the top digit down while it shows nothing (0, no dp);
  // digit 0 is always kept.
  always_comb begin
    w_mask = ssd_scan_driver_port_en;
    w_stop = 1'b0;
    if (ssd_scan_driver_port_lzb) begin
      for (int k = NUM_DIGITS - 1; k > 0; k--) begin
        if (!w_stop &&
            ssd_scan_driver_port_inp[4*k +: 4] == 4'd0 &&
            !ssd_scan_driver_port_idp[k]) begin
          w_mask[k] = 1'b0;
        end else begin
          w_stop = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nib    <= '0;
      r_dp     <= '0;
      r_mask   <= '0;
      r_bright <= '1;
    end else if (ssd_scan_driver_port_load) begin
      r_nib    <= ssd_scan_driver_port_inp;
      r_dp     <= ssd_scan_driver_port_idp;
      r_mask   <= w_mask;
      r_bright <= ssd_scan_driver_port_bright;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre   <= '0;
      r_idx   <= '0;
      r_frame <= 1'b0;
      r_phase <= '0;
    end else begin
      r_phase <= r_phase + 1'b1;
      r_frame <= w_tick && w_last;
      if (w_tick) begin
        r_pre <= '0;
        r_idx <= w_last ? '0 : r_idx + 1'b1;
      end else begin
        r_pre <= r_pre + 1'b1;
      end
    end
  end

  assign w_nib = r_nib[r_idx];

  always_comb begin
    w_seg = 7'h7F;
    unique case (w_nib)
      4'h0: w_seg = 7'h40;
      4'h1: w_seg = 7'h79;
      4'h2: w_seg = 7'h24;
      4'h3: w_seg = 7'h30;
      4'h4: w_seg = 7'h19;
      4'h5: w_seg = 7'h12;
      4'h6: w_seg = 7'h02;
      4'h7: w_seg = 7'h78;
      4'h8: w_seg = 7'h00;
      4'h9: w_seg = 7'h10;
      4'hA: w_seg = 7'h08;
      4'hB: w_seg = 7'h03;
      4'hC: w_seg = 7'h46;
      4'hD: w_seg = 7'h21;
      4'hE: w_seg = 7'h06;
      4'hF: w_seg = 7'h0E;
    endcase
  end

  // All-ones brightness is fully on, so the phase compare never darkens it.
  assign w_lit = r_mask[r_idx] &&
                 ((r_phase < r_bright) || (&r_bright));

  always_comb begin
    w_an  = '1;
    w_cc  = 7'h7F;
    w_odp = 1'b1;
    if (w_lit) begin
      w_an[r_idx] = 1'b0;
      w_cc        = w_seg;
      w_odp       = ~r_dp[r_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an  <= '1;
      r_cc  <= 7'h7F;
      r_odp <= 1'b1;
    end else begin
      r_an  <= w_an;
      r_cc  <= w_cc;
      r_odp <= w_odp;
    end
  end

  assign ssd_scan_driver_port_an    = r_an;
  assign ssd_scan_driver_port_cc    = r_cc;
  assign ssd_scan_driver_port_odp   = r_odp;
  assign ssd_scan_driver_port_idx   = r_idx;
  assign ssd_scan_driver_port_frame = r_frame;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Bench for ssd_scan_driver: 4 digits, 4-cycle slots, 2-bit brightness.
// Cycle model plus literal pin checks over directed scenarios.
module tb_ssd_scan_driver;

  localparam int N = 4;
  localparam int R = 4;
  localparam int B = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [15:0]  inp = '0;
  logic [3:0]   idp = '0;
  logic [3:0]   en = '0;
  logic         lzb = 1'b0;
  logic [B-1:0] bright = '0;
  logic         load = 1'b0;
  logic [6:0]   cc;
  logic         odp;
  logic [3:0]   an;
  logic [1:0]   idx;
  logic         frame;

  int vec = 0;
  int err = 0;

  ssd_scan_driver #(
    .NUM_DIGITS (N),
    .REFRESH_DIV(R),
    .BRIGHT_W   (B)
  ) dut (
    .ssd_scan_driver_port_clk   (clk),
    .ssd_scan_driver_port_rst_n (rst_n),
    .ssd_scan_driver_port_inp   (inp),
    .ssd_scan_driver_port_idp   (idp),
    .ssd_scan_driver_port_en    (en),
    .ssd_scan_driver_port_lzb   (lzb),
    .ssd_scan_driver_port_bright(bright),
    .ssd_scan_driver_port_load  (load),
    .ssd_scan_driver_port_cc    (cc),
    .ssd_scan_driver_port_odp   (odp),
    .ssd_scan_driver_port_an    (an),
    .ssd_scan_driver_port_idx   (idx),
    .ssd_scan_driver_port_frame (frame)
  );

  always #5 clk = ~clk;

  logic [6:0] dec [16] = '{7'h40, 7'h79, 7'h24, 7'h30,
                           7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03,
                           7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Mask keeps enabled digits up to the highest one showing something.
  function automatic logic [3:0] eff_mask(logic [15:0] nb, logic [3:0] dp,
                                          logic [3:0] e, logic lz);
    int top;
    top = 0;
    if (!lz) return e;
    for (int k = 0; k < N; k++)
      if (nb[4*k +: 4] != 4'd0 || dp[k]) top = k;
    return e & 4'((2 << top) - 1);
  endfunction

  int         n;
  logic [15:0] m_nib;
  logic [3:0]  m_dp, m_mask;
  logic [B-1:0] m_br;
  logic [3:0]  e_an;
  logic [6:0]  e_cc;
  logic        e_odp;
  logic [1:0]  e_idx;
  logic        e_frame;
  int          ci, ph;
  logic        lit;

  // n = rising edges since reset release; slot and phase follow from it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n = 0; m_nib = '0; m_dp = '0; m_mask = '0; m_br = '1;
      e_an = 4'hF; e_cc = 7'h7F; e_odp = 1'b1; e_idx = '0; e_frame = 1'b0;
    end else begin
      ci  = (n / R) % N;
      ph  = n % (1 << B);
      lit = m_mask[ci] && (ph < int'(m_br) || m_br == '1);
      e_an  = lit ? ~(4'b1 << ci) : 4'hF;
      e_cc  = lit ? dec[m_nib[4*ci +: 4]] : 7'h7F;
      e_odp = lit ? ~m_dp[ci] : 1'b1;
      if (load) begin
        m_nib  = inp;
        m_dp   = idp;
        m_mask = eff_mask(inp, idp, en, lzb);
        m_br   = bright;
      end
      n++;
      e_idx   = 2'((n / R) % N);
      e_frame = (n % (N * R)) == 0;
    end
  end

  always @(negedge clk) begin
    chk("an", an, e_an);
    chk("cc", cc, e_cc);
    chk("odp", odp, e_odp);
    chk("idx", idx, e_idx);
    chk("frame", frame, e_frame);
  end

  task automatic cyc(int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic do_load(logic [15:0] i, logic [3:0] d, logic [3:0] e,
                         logic z, logic [B-1:0] b);
    @(negedge clk);
    inp = i; idp = d; en = e; lzb = z; bright = b; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  function automatic int slot();
    return ((n - 1) / R) % N;
  endfunction

  logic [6:0] sw_cc [4] = '{7'h40, 7'h79, 7'h00, 7'h0E};
  logic [3:0] sw_an [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

  initial begin
    int cnt;
    rst_n = 1'b0;
    cyc(3);
    chk("rst_an", an, 4'hF);
    chk("rst_cc", cc, 7'h7F);
    rst_n = 1'b1;
    cyc(6);
    chk("blank_an", an, 4'hF);

    do_load(16'hF810, 4'h0, 4'hF, 1'b0, 2'd3);
    cyc(1);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("sweep_cc", cc, sw_cc[slot()]);
      chk("sweep_an", an, sw_an[slot()]);
      if (frame) cnt++;
    end
    chk("frame_cnt", cnt, 1);

    do_load(16'hF810, 4'b0101, 4'b1011, 1'b0, 2'd3);
    cyc(1);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (slot() == 2) chk("dis_an", an, 4'hF);
      if (slot() == 0) chk("dp0_odp", odp, 1'b0);
      if (slot() == 1) chk("dp1_odp", odp, 1'b1);
    end

    do_load(16'h0005, 4'h0, 4'hF, 1'b1, 2'd3);
    cyc(1);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("lzb_an", an, slot() == 0 ? 4'hE : 4'hF);
    end
    do_load(16'h0000, 4'h0, 4'hF, 1'b1, 2'd3);
    cyc(1);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (slot() == 0) chk("lzb0_cc", cc, 7'h40);
      else chk("lzb0_an", an, 4'hF);
    end
    do_load(16'h0005, 4'h0, 4'hF, 1'b0, 2'd3);
    cyc(1);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (an != 4'hF) cnt++;
    end
    chk("nolzb_lit", cnt, 16);

    do_load(16'h1234, 4'h0, 4'hF, 1'b0, 2'd1);
    cyc(1);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (an != 4'hF) cnt++;
    end
    chk("br1_lit", cnt, 4);
    do_load(16'h1234, 4'h0, 4'hF, 1'b0, 2'd0);
    cyc(1);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (an != 4'hF) cnt++;
    end
    chk("br0_lit", cnt, 0);

    do_load(16'h8888, 4'h0, 4'hF, 1'b0, 2'd3);
    inp = 16'h2222;
    cyc(8);
    chk("tear_hold", cc, 7'h00);
    cnt = 0;
    while (n % R != R - 1 && cnt < 8) begin
      @(negedge clk);
      cnt++;
    end
    chk("tick_align", n % R, R - 1);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("tear_old", cc, 7'h00);
    @(negedge clk);
    chk("tear_new", cc, 7'h24);

    cyc(5);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_an", an, 4'hF);
    chk("async_cc", cc, 7'h7F);
    chk("async_odp", odp, 1'b1);
    chk("async_idx", idx, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rel_idx", idx, 2'd0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (an != 4'hF) cnt++;
    end
    chk("post_rst_blank", cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
